fir_filter_mc: RTL and testbench



---
 rtl/fir_filter_mc_if.sv | 44 ++++
 rtl/fir_filter_mc.sv | 151 +++++++++++++++
 tb/tb_fir_filter_mc.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_mc_if.sv
// Handshake, coefficient and control bundle for fir_filter_mc.
// slave = filter side, master = source/sink side.
interface fir_filter_mc_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic [NCH*DATA_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [NCH*OUT_W-1:0]  out_data;
  logic [NCH-1:0]        out_sat;
  logic                  out_valid;
  logic                  out_ready;
  logic                  coef_wr;
  logic [AW-1:0]         coef_addr;
  logic [COEF_W-1:0]     coef_data;
  logic                  clr;
  logic                  busy;

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_sat, out_valid,
    input  out_ready,
    input  coef_wr, coef_addr, coef_data,
    input  clr,
    output busy
  );

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_sat, out_valid,
    output out_ready,
    output coef_wr, coef_addr, coef_data,
    output clr,
    input  busy
  );
endinterface

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR: shared runtime coefficients, one sequential
// MAC per channel, rounded/saturated output with valid/ready.
module fir_filter_mc #(
  parameter int NCH       = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic            clk,
  input logic            rst,
  fir_filter_mc_if.slave bus
);
  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  // One guard bit so the rounding add can never wrap.
  localparam int RW    = ACC_W + 1;
  localparam int SHA   = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND =
    (OUT_SHIFT > 0) ? (RW'(1) << SHA) : '0;
  localparam logic signed [RW-1:0] OMAX =
    {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN =
    {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MAC,
    OUT
  } state_t;

  state_t                    state_q;
  logic [AW-1:0]             k_q;
  logic signed [DATA_W-1:0]  dline_q [NCH][TAPS];
  logic signed [COEF_W-1:0]  coef_q  [TAPS];
  logic signed [DATA_W-1:0]  samp_q  [NCH];
  logic signed [ACC_W-1:0]   acc_q   [NCH];
  logic [NCH*OUT_W-1:0]      out_data_q;
  logic [NCH-1:0]            out_sat_q;
  logic                      out_valid_q;
  logic                      in_ready_q;
  logic                      busy_q;

  logic signed [PW-1:0]      prod    [NCH];
  logic signed [ACC_W-1:0]   acc_d   [NCH];
  logic signed [RW-1:0]      ext     [NCH];
  logic signed [RW-1:0]      rr      [NCH];
  logic [NCH*OUT_W-1:0]      out_data_d;
  logic [NCH-1:0]            out_sat_d;

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;

  // Next accumulator per channel and its rounded, saturated image.
  always_comb begin
    out_data_d = '0;
    out_sat_d  = '0;
    for (int c = 0; c < NCH; c++) begin
      prod[c]  = dline_q[c][k_q] * coef_q[k_q];
      acc_d[c] = acc_q[c] + ACC_W'(prod[c]);
      ext[c]   = RW'(acc_d[c]);
      rr[c]    = (ext[c] + RND) >>> OUT_SHIFT;
      if (rr[c] > OMAX) begin
        out_data_d[c*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
        out_sat_d[c] = 1'b1;
      end else if (rr[c] < OMIN) begin
        out_data_d[c*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
        out_sat_d[c] = 1'b1;
      end else begin
        out_data_d[c*OUT_W +: OUT_W] = rr[c][OUT_W-1:0];
      end
    end
  end

  // Control FSM with delay lines, coefficients and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int t = 0; t < TAPS; t++)
        coef_q[t] <= '0;
      for (int c = 0; c < NCH; c++) begin
        samp_q[c] <= '0;
        acc_q[c]  <= '0;
        for (int t = 0; t < TAPS; t++)
          dline_q[c][t] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.coef_wr && int'(bus.coef_addr) < TAPS)
            coef_q[bus.coef_addr] <= bus.coef_data;
          if (bus.clr) begin
            for (int c = 0; c < NCH; c++)
              for (int t = 0; t < TAPS; t++)
                dline_q[c][t] <= '0;
          end
          if (bus.in_valid) begin
            for (int c = 0; c < NCH; c++)
              samp_q[c] <= bus.in_data[c*DATA_W +: DATA_W];
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          for (int c = 0; c < NCH; c++) begin
            for (int t = TAPS - 1; t > 0; t--)
              dline_q[c][t] <= dline_q[c][t-1];
            dline_q[c][0] <= samp_q[c];
            acc_q[c]      <= '0;
          end
          k_q     <= '0;
          state_q <= MAC;
        end
        MAC: begin
          for (int c = 0; c < NCH; c++)
            acc_q[c] <= acc_d[c];
          k_q <= k_q + 1'b1;
          if (k_q == AW'(TAPS - 1)) begin
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: vector table through a scoreboard queue
// plus directed latency, stall, ignored-write, clear and reset cases.
module tb_fir_filter_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  s;
  } exp_t;

  typedef struct packed {
    logic [1:0]  set;
    logic        clr;
    logic [63:0] d;
    logic [63:0] e;
    logic [3:0]  s;
  } row_t;

  exp_t q[$];
  row_t rows [18];

  fir_filter_mc_if bus ();

  fir_filter_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] p4(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got %h with no pending sample",
                 bus.out_data);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        if (bus.out_data !== ex.d || bus.out_sat !== ex.s) begin
          n_bad++;
          $display("FAIL out_vec: got %h sat %b want %h sat %b",
                   bus.out_data, bus.out_sat, ex.d, ex.s);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: in_ready %b want 1", bus.in_ready);
    end
  endtask

  task automatic wr_coef(int k, int v);
    wait_idle();
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 3'(k);
    bus.coef_data = 16'(v);
    @(posedge clk);
    #1 bus.coef_wr = 1'b0;
  endtask

  task automatic load_set(int id);
    for (int k = 0; k < 8; k++) begin
      if (id == 1)      wr_coef(k, (k == 0) ? 16384 : 0);
      else if (id == 2) wr_coef(k, 1000 * k);
      else              wr_coef(k, 32767);
    end
  endtask

  task automatic send(logic c, logic [63:0] d, logic [63:0] e,
                      logic [3:0] s, bit push);
    exp_t ex;
    wait_idle();
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.clr      = c;
    acc_cyc      = cyc;
    ex.d = e;
    ex.s = s;
    if (push) q.push_back(ex);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending %0d want 0", q.size());
    end
  endtask

  task automatic wait_ov();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ov_timeout: out_valid %b want 1", bus.out_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.clr       = 1'b0;

    rows[0]  = '{2'd1, 1'b1, p4(1000, -1000, 32767, 0),
                 p4(500, -500, 16384, 0), 4'b0000};
    rows[1]  = '{2'd2, 1'b1, p4(32767, 0, 0, 0),
                 p4(0, 0, 0, 0), 4'b0000};
    for (int i = 2; i < 10; i++)
      rows[i] = '{2'd0, 1'b0, p4(0, 0, 0, 0),
                  p4((i < 9) ? 1000 * (i - 1) : 0, 0, 0, 0), 4'b0000};
    rows[10] = '{2'd3, 1'b1, p4(32767, -32768, 0, 0),
                 p4(32766, -32767, 0, 0), 4'b0000};
    for (int i = 11; i < 18; i++)
      rows[i] = '{2'd0, 1'b0, p4(32767, -32768, 0, 0),
                  p4(32767, -32768, 0, 0), 4'b0011};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);

    for (int i = 0; i < 18; i++) begin
      if (rows[i].set != 2'd0) load_set(int'(rows[i].set));
      send(rows[i].clr, rows[i].d, rows[i].e, rows[i].s, 1'b1);
      if (i == 0) begin
        wait_ov();
        chk("latency", 64'(cyc - acc_cyc), 64'd10);
      end
    end
    drain();

    bus.out_ready = 1'b0;
    send(1'b1, p4(100, -100, 0, 1), p4(100, -100, 0, 1), 4'b0, 1'b1);
    wait_ov();
    bus.in_data  = p4(7, 7, 7, 7);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_data", bus.out_data, p4(100, -100, 0, 1));
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("stall_idle_busy", 64'(bus.busy), 64'd0);
    repeat (12) @(negedge clk);
    chk("stall_no_extra", 64'(bus.out_valid), 64'd0);
    drain();

    send(1'b1, p4(1000, 0, 0, 0), p4(1000, 0, 0, 0), 4'b0, 1'b1);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 16'd0;
    repeat (6) @(posedge clk);
    #1 bus.coef_wr = 1'b0;
    send(1'b0, p4(2000, 0, 0, 0), p4(3000, 0, 0, 0), 4'b0, 1'b1);
    send(1'b1, p4(5, 0, 0, 0), p4(5, 0, 0, 0), 4'b0, 1'b1);
    drain();

    send(1'b0, p4(1000, 1000, 1000, 1000), '0, 4'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_data", bus.out_data, 64'd0);
    chk("abort_sat", 64'(bus.out_sat), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i % 4 == 0)
        chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    send(1'b0, p4(1000, -1000, 500, 7), p4(0, 0, 0, 0), 4'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
